// File: rtl/ann_pkg.sv
// Shared definitions for the drowsiness ANN and its input feeder.
package ann_pkg;
  localparam int N_IN   = 30;
  localparam int DATA_W = 10;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;
endpackage

// File: rtl/ann_input_window.sv
// Sliding-window feeder for the drowsiness ANN: collects samples, launches on N (then STRIDE) new ones.
// Optional INPUT_CLAMP_EN: accepted samples above MAX_VAL are stored as MAX_VAL.
//
// state | meaning
// FILL  | collecting samples, sample_ready=1
// RUN   | window frozen, start=1, waiting for ann_done
module ann_input_window
  import ann_pkg::*;
#(
  parameter int N       = N_IN,
  parameter int W       = DATA_W,
  parameter int STRIDE  = 10,
  parameter int MAX_VAL = 999
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  input  logic         ann_done,
  output logic [W-1:0] window [0:N-1],
  output logic         start,
  output logic [7:0]   dropped
);

  localparam int CNT_W = $clog2(N + 1);

  win_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] need;
  logic             first;
  logic [W-1:0]     stored;

  assign sample_ready = (state == FILL);
  assign need         = first ? CNT_W'(N) : CNT_W'(STRIDE);

`ifdef INPUT_CLAMP_EN
  assign stored = (sample_in > W'(MAX_VAL)) ? W'(MAX_VAL) : sample_in;
`else
  assign stored = sample_in;
`endif

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state   <= FILL;
      start   <= 1'b0;
      cnt     <= '0;
      first   <= 1'b1;
      dropped <= '0;
      for (int i = 0; i < N; i++) window[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (sample_valid) begin
            for (int i = 0; i < N - 1; i++) window[i] <= window[i+1];
            window[N-1] <= stored;
            if (cnt + 1'b1 == need) begin
              state <= RUN;
              start <= 1'b1;
              cnt   <= '0;
              first <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // The release cycle is not counted as a drop: the window reopens on this edge.
          if (ann_done) begin
            state <= FILL;
            start <= 1'b0;
          end else if (sample_valid && dropped != 8'hFF) begin
            dropped <= dropped + 8'd1;
          end
        end
        default: begin
          state <= FILL;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule
